// File: rtl/wb_pipe_stage.sv
// Pipelined Wishbone request register slice with a two-entry skid buffer.
// Request path and stall are registered; responses pass straight through.
`timescale 1ns/1ps
module wb_pipe_stage #(
    parameter int unsigned ADR_WIDTH  = 16,
    parameter int unsigned DAT_WIDTH  = 16,
    parameter int unsigned SEL_WIDTH  = 2,
    parameter int unsigned TGA_WIDTH  = 1,
    parameter int unsigned TGC_WIDTH  = 1,
    parameter int unsigned TGRD_WIDTH = 1,
    parameter int unsigned TGWD_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  async_rst_n_i,
    // initiator side
    input  logic                  itr_cyc_i,
    input  logic                  itr_stb_i,
    input  logic                  itr_we_i,
    input  logic                  itr_lock_i,
    input  logic [SEL_WIDTH-1:0]  itr_sel_i,
    input  logic [ADR_WIDTH-1:0]  itr_adr_i,
    input  logic [DAT_WIDTH-1:0]  itr_dat_i,
    input  logic [TGA_WIDTH-1:0]  itr_tga_i,
    input  logic [TGC_WIDTH-1:0]  itr_tgc_i,
    input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
    output logic                  itr_ack_o,
    output logic                  itr_err_o,
    output logic                  itr_rty_o,
    output logic                  itr_stall_o,
    output logic [DAT_WIDTH-1:0]  itr_dat_o,
    output logic [TGRD_WIDTH-1:0] itr_tgd_o,
    // target side
    output logic                  tgt_cyc_o,
    output logic                  tgt_stb_o,
    output logic                  tgt_we_o,
    output logic                  tgt_lock_o,
    output logic [SEL_WIDTH-1:0]  tgt_sel_o,
    output logic [ADR_WIDTH-1:0]  tgt_adr_o,
    output logic [DAT_WIDTH-1:0]  tgt_dat_o,
    output logic [TGA_WIDTH-1:0]  tgt_tga_o,
    output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
    output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
    input  logic                  tgt_ack_i,
    input  logic                  tgt_err_i,
    input  logic                  tgt_rty_i,
    input  logic                  tgt_stall_i,
    input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
    input  logic [TGRD_WIDTH-1:0] tgt_tgd_i
);

    localparam int unsigned EntryW =
        1 + SEL_WIDTH + ADR_WIDTH + DAT_WIDTH + TGA_WIDTH + TGC_WIDTH + TGWD_WIDTH;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StTwo   = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              stall_q;
    logic [EntryW-1:0] main_q, main_d;
    logic [EntryW-1:0] skid_q, skid_d;
    logic [EntryW-1:0] req;
    logic              push, pop;

    assign req = {itr_we_i, itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i};

    assign tgt_stb_o = (state_q != StEmpty) & itr_cyc_i;
    assign push      = itr_cyc_i & itr_stb_i & ~stall_q;
    assign pop       = tgt_stb_o & ~tgt_stall_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    main_d  = req;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    main_d = req;
                end else if (pop) begin
                    state_d = StEmpty;
                end else if (push) begin
                    skid_d  = req;
                    state_d = StTwo;
                end
            end
            StTwo: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Cycle abort discards everything still buffered.
        if (!itr_cyc_i) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            state_q <= StEmpty;
            stall_q <= 1'b0;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= (state_d == StTwo);
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign itr_stall_o = stall_q;
    assign {tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o} = main_q;

    assign tgt_cyc_o  = itr_cyc_i;
    assign tgt_lock_o = itr_lock_i;

    assign itr_ack_o = tgt_ack_i & itr_cyc_i;
    assign itr_err_o = tgt_err_i & itr_cyc_i;
    assign itr_rty_o = tgt_rty_i & itr_cyc_i;
    assign itr_dat_o = tgt_dat_i;
    assign itr_tgd_o = tgt_tgd_i;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Directed and random-soak bench for wb_pipe_stage with a queue model of
// the accepted request stream.
`timescale 1ns/1ps
module tb_wb_pipe_stage;

    logic        clk_i = 1'b0;
    logic        async_rst_n_i;
    logic        itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i;
    logic [1:0]  itr_sel_i;
    logic [15:0] itr_adr_i, itr_dat_i;
    logic [0:0]  itr_tga_i, itr_tgc_i, itr_tgd_i;
    logic        itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o;
    logic [15:0] itr_dat_o;
    logic [0:0]  itr_tgd_o;
    logic        tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o;
    logic [1:0]  tgt_sel_o;
    logic [15:0] tgt_adr_o, tgt_dat_o;
    logic [0:0]  tgt_tga_o, tgt_tgc_o, tgt_tgd_o;
    logic        tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i;
    logic [15:0] tgt_dat_i;
    logic [0:0]  tgt_tgd_i;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk_i = ~clk_i;

    wb_pipe_stage dut (
        .clk_i         (clk_i),
        .async_rst_n_i (async_rst_n_i),
        .itr_cyc_i     (itr_cyc_i),
        .itr_stb_i     (itr_stb_i),
        .itr_we_i      (itr_we_i),
        .itr_lock_i    (itr_lock_i),
        .itr_sel_i     (itr_sel_i),
        .itr_adr_i     (itr_adr_i),
        .itr_dat_i     (itr_dat_i),
        .itr_tga_i     (itr_tga_i),
        .itr_tgc_i     (itr_tgc_i),
        .itr_tgd_i     (itr_tgd_i),
        .itr_ack_o     (itr_ack_o),
        .itr_err_o     (itr_err_o),
        .itr_rty_o     (itr_rty_o),
        .itr_stall_o   (itr_stall_o),
        .itr_dat_o     (itr_dat_o),
        .itr_tgd_o     (itr_tgd_o),
        .tgt_cyc_o     (tgt_cyc_o),
        .tgt_stb_o     (tgt_stb_o),
        .tgt_we_o      (tgt_we_o),
        .tgt_lock_o    (tgt_lock_o),
        .tgt_sel_o     (tgt_sel_o),
        .tgt_adr_o     (tgt_adr_o),
        .tgt_dat_o     (tgt_dat_o),
        .tgt_tga_o     (tgt_tga_o),
        .tgt_tgc_o     (tgt_tgc_o),
        .tgt_tgd_o     (tgt_tgd_o),
        .tgt_ack_i     (tgt_ack_i),
        .tgt_err_i     (tgt_err_i),
        .tgt_rty_i     (tgt_rty_i),
        .tgt_stall_i   (tgt_stall_i),
        .tgt_dat_i     (tgt_dat_i),
        .tgt_tgd_i     (tgt_tgd_i)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [37:0] itr_req();
        return {itr_we_i, itr_sel_i, itr_adr_i, itr_dat_i, itr_tga_i, itr_tgc_i, itr_tgd_i};
    endfunction

    function automatic logic [37:0] tgt_req();
        return {tgt_we_o, tgt_sel_o, tgt_adr_o, tgt_dat_o, tgt_tga_o, tgt_tgc_o, tgt_tgd_o};
    endfunction

    logic [37:0] model_q[$];
    logic [37:0] exp_req;
    logic        do_push, do_pop;

    initial begin
        async_rst_n_i = 1'b0;
        itr_cyc_i = 1'b0; itr_stb_i = 1'b0; itr_we_i = 1'b0; itr_lock_i = 1'b0;
        itr_sel_i = '0; itr_adr_i = '0; itr_dat_i = '0;
        itr_tga_i = '0; itr_tgc_i = '0; itr_tgd_i = '0;
        tgt_ack_i = 1'b0; tgt_err_i = 1'b0; tgt_rty_i = 1'b0; tgt_stall_i = 1'b0;
        tgt_dat_i = '0; tgt_tgd_i = '0;

        // reset state
        #2;
        itr_cyc_i = 1'b1;
        #1;
        check_eq("rst_stall", itr_stall_o, 0);
        check_eq("rst_stb", tgt_stb_o, 0);
        check_eq("rst_req", tgt_req(), 0);
        check_eq("rst_cyc_follow", tgt_cyc_o, 1);
        @(negedge clk_i);
        async_rst_n_i = 1'b1;
        itr_we_i = 1'b1;
        tick();

        // back-to-back writes with no target stall
        for (int i = 0; i < 4; i++) begin
            itr_stb_i = 1'b1;
            itr_adr_i = 16'h0010 + 16'(i);
            tick();
            check_eq("b2b_stb", tgt_stb_o, 1);
            check_eq("b2b_adr", tgt_adr_o, 64'h10 + 64'(i));
            check_eq("b2b_stall", itr_stall_o, 0);
        end
        itr_stb_i = 1'b0;
        tick();
        check_eq("b2b_idle", tgt_stb_o, 0);

        // skid fill: A, then B into skid, C held off
        itr_stb_i = 1'b1; itr_adr_i = 16'h0100;
        tick();
        tgt_stall_i = 1'b1; itr_adr_i = 16'h0104;
        tick();
        check_eq("skid_stall_up", itr_stall_o, 1);
        check_eq("skid_adr_a", tgt_adr_o, 64'h100);
        itr_adr_i = 16'h0108;
        tick();
        check_eq("skid_stall_hold", itr_stall_o, 1);
        check_eq("skid_adr_a2", tgt_adr_o, 64'h100);
        tgt_stall_i = 1'b0;
        tick();
        check_eq("skid_adr_b", tgt_adr_o, 64'h104);
        check_eq("skid_stall_down", itr_stall_o, 0);
        tick();
        check_eq("skid_adr_c", tgt_adr_o, 64'h108);
        check_eq("skid_stb_c", tgt_stb_o, 1);
        itr_stb_i = 1'b0;
        tick();
        check_eq("skid_drain", tgt_stb_o, 0);

        // abort from TWO
        itr_stb_i = 1'b1; itr_adr_i = 16'h0300;
        tick();
        tgt_stall_i = 1'b1; itr_adr_i = 16'h0304;
        tick();
        check_eq("abort_pre_stall", itr_stall_o, 1);
        itr_cyc_i = 1'b0; itr_stb_i = 1'b0;
        tick();
        check_eq("abort_stb", tgt_stb_o, 0);
        check_eq("abort_stall", itr_stall_o, 0);
        check_eq("abort_cyc", tgt_cyc_o, 0);
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1; itr_adr_i = 16'h0200; tgt_stall_i = 1'b0;
        tick();
        check_eq("abort_new_stb", tgt_stb_o, 1);
        check_eq("abort_new_adr", tgt_adr_o, 64'h200);
        itr_stb_i = 1'b0;
        tick();

        // response gating
        tgt_ack_i = 1'b1; tgt_dat_i = 16'hBEEF; tgt_tgd_i = 1'b1;
        #1;
        check_eq("resp_ack", itr_ack_o, 1);
        check_eq("resp_dat", itr_dat_o, 64'hBEEF);
        check_eq("resp_tgd", itr_tgd_o, 1);
        tgt_ack_i = 1'b0; tgt_err_i = 1'b1; tgt_rty_i = 1'b1;
        #1;
        check_eq("resp_err", itr_err_o, 1);
        check_eq("resp_rty", itr_rty_o, 1);
        itr_cyc_i = 1'b0; tgt_ack_i = 1'b1;
        #1;
        check_eq("resp_ack_gated", itr_ack_o, 0);
        check_eq("resp_err_gated", itr_err_o, 0);
        tgt_ack_i = 1'b0; tgt_err_i = 1'b0; tgt_rty_i = 1'b0; itr_cyc_i = 1'b1;
        tick();

        // async reset while in TWO
        itr_stb_i = 1'b1; itr_adr_i = 16'h0400;
        tick();
        tgt_stall_i = 1'b1; itr_adr_i = 16'h0404;
        tick();
        itr_stb_i = 1'b0;
        check_eq("arst_pre_stall", itr_stall_o, 1);
        #2;
        async_rst_n_i = 1'b0;
        #1;
        check_eq("arst_stb", tgt_stb_o, 0);
        check_eq("arst_stall", itr_stall_o, 0);
        check_eq("arst_adr", tgt_adr_o, 0);
        @(negedge clk_i);
        async_rst_n_i = 1'b1;
        tgt_stall_i = 1'b0;
        tick();

        // random soak against a queue model of accepted requests
        model_q.delete();
        for (int c = 0; c < 10000; c++) begin
            itr_cyc_i   = ($urandom_range(0, 63) != 0);
            itr_stb_i   = $urandom_range(0, 1);
            tgt_stall_i = $urandom_range(0, 1);
            itr_we_i    = $urandom_range(0, 1);
            itr_lock_i  = $urandom_range(0, 1);
            itr_sel_i   = 2'($urandom);
            itr_adr_i   = 16'($urandom);
            itr_dat_i   = 16'($urandom);
            itr_tga_i   = 1'($urandom);
            itr_tgc_i   = 1'($urandom);
            itr_tgd_i   = 1'($urandom);
            @(negedge clk_i);
            check_eq("soak_stb_level", tgt_stb_o, itr_cyc_i && (model_q.size() != 0));
            check_eq("soak_stall_level", itr_stall_o, model_q.size() == 2);
            check_eq("soak_lock", tgt_lock_o, itr_lock_i);
            do_push = itr_cyc_i & itr_stb_i & ~itr_stall_o;
            do_pop  = tgt_stb_o & ~tgt_stall_i;
            if (do_pop) begin
                if (model_q.size() == 0) begin
                    check_eq("soak_pop_empty", 1, 0);
                end else begin
                    exp_req = model_q.pop_front();
                    check_eq("soak_req", tgt_req(), exp_req);
                end
            end
            if (!itr_cyc_i) model_q.delete();
            else if (do_push) model_q.push_back(itr_req());
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
